// File: rtl/arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// arb_pkg : shared state encoding, defaults and round-robin search
// Rev 1.0
// ---------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int ARB_HOLD_MAX_DEF = 8;
    localparam int ARB_NREQ         = 4;

    // First set request bit searching circularly from last+1; returns last if none.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int off = 1; off <= ARB_NREQ; off++) begin
            idx = last + 2'(off);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------
// rr_grant_arbiter_if : request/grant bundle between requesters and arbiter
// Rev 1.0
// ---------------------------------------------------------------------
interface rr_grant_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt_n;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    modport master (output req, done, input gnt_n, gnt_idx, busy, timeout);
    modport slave  (input req, done, output gnt_n, gnt_idx, busy, timeout);
endinterface
`default_nettype wire

// File: rtl/dec2to4_n.sv
`default_nettype none
// ---------------------------------------------------------------------
// dec2to4_n : gate-level 2-to-4 decoder, active-low enable and outputs
// Rev 1.0
// ---------------------------------------------------------------------
module dec2to4_n (
    input  logic [1:0] a,
    input  logic       en_n,
    output logic [3:0] y_n
);
    logic w_a0_n;
    logic w_a1_n;
    logic w_en;

    not  u_inv_a0 (w_a0_n, a[0]);
    not  u_inv_a1 (w_a1_n, a[1]);
    not  u_inv_en (w_en,   en_n);

    nand u_nand_0 (y_n[0], w_a1_n, w_a0_n, w_en);
    nand u_nand_1 (y_n[1], w_a1_n, a[0],   w_en);
    nand u_nand_2 (y_n[2], a[1],   w_a0_n, w_en);
    nand u_nand_3 (y_n[3], a[1],   a[0],   w_en);
endmodule
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------
// rr_grant_arbiter : 4-way round-robin arbiter with hold-time limit
// Rev 1.0
// ---------------------------------------------------------------------
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = ARB_HOLD_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_grant_arbiter_if.slave    bus
);
    localparam logic [3:0] c_HOLD_LIM = 4'(HOLD_MAX - 1);

    arb_state_t r_state;
    logic [1:0] r_gnt_idx;
    logic [1:0] r_last_idx;
    logic [3:0] r_cnt;
    logic [3:0] r_gnt_n;
    logic       r_busy;
    logic       r_timeout;

    logic [1:0] w_pick;
    logic       w_start;
    logic [3:0] w_dec_n;
    logic       w_hold_req;
    logic       w_limit;
    logic       w_exit;

    assign w_pick     = rr_pick(bus.req, r_last_idx);
    assign w_start    = (r_state == IDLE) && (|bus.req);
    assign w_hold_req = bus.req[r_gnt_idx];
    assign w_limit    = (r_cnt == c_HOLD_LIM);
    assign w_exit     = bus.done || !w_hold_req || w_limit;

    // Decoder sees the index being loaded, so gnt_n lines up with the GRANT state.
    dec2to4_n u_dec (
        .a    (w_pick),
        .en_n (!w_start),
        .y_n  (w_dec_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt_n    <= 4'b1111;
            r_gnt_idx  <= 2'd3;
            r_last_idx <= 2'd3;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_start) begin
                        r_state   <= GRANT;
                        r_gnt_idx <= w_pick;
                        r_gnt_n   <= w_dec_n;
                        r_busy    <= 1'b1;
                        r_cnt     <= 4'd0;
                    end
                end
                GRANT: begin
                    if (w_exit) begin
                        r_state   <= RELEASE;
                        r_gnt_n   <= 4'b1111;
                        r_busy    <= 1'b0;
                        // Only a pure counter expiry is a forced release.
                        r_timeout <= w_limit && !bus.done && w_hold_req;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RELEASE: begin
                    r_state    <= IDLE;
                    r_last_idx <= r_gnt_idx;
                    r_cnt      <= 4'd0;
                    r_timeout  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_gnt_n   <= 4'b1111;
                    r_busy    <= 1'b0;
                    r_timeout <= 1'b0;
                    r_cnt     <= 4'd0;
                end
            endcase
        end
    end

    assign bus.gnt_n   = r_gnt_n;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;
endmodule
`default_nettype wire
